pcm_fifo_arbiter: RTL

Multi-channel PCM-to-FIFO write scheduler for the I2S capture path. It accepts 16-bit PCM samples from up to `NUM_CH` I2S decimator channels and holds one sample per channel. It grants the single 8-bit TX FIFO write port round-robin and writes each sample as an atomic little-endian byte frame, so bytes from different samples never interleave. It sits between the I2S receivers and the TX FIFO that the SPI slave drains.

---
 rtl/pcm_fifo_arbiter_if.sv | 28 ++
 rtl/pcm_fifo_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pcm_fifo_arbiter_if.sv
// PCM capture / TX FIFO write bus for pcm_fifo_arbiter.
// master: the arbiter (consumes PCM strobes, drives FIFO writes).
// slave:  the surrounding environment (I2S decimators plus TX FIFO).
interface pcm_fifo_arbiter_if #(
  parameter int unsigned NUM_CH = 4
);
  logic [NUM_CH-1:0]    pcm_valid;
  logic [NUM_CH*16-1:0] pcm_data;
  logic                 fifo_full;
  logic                 fifo_wr_en;
  logic [7:0]           fifo_wdata;

  modport master (
    input  pcm_valid,
    input  pcm_data,
    input  fifo_full,
    output fifo_wr_en,
    output fifo_wdata
  );

  modport slave (
    output pcm_valid,
    output pcm_data,
    output fifo_full,
    input  fifo_wr_en,
    input  fifo_wdata
  );
endinterface

// File: rtl/pcm_fifo_arbiter.sv
// Multi-channel PCM-to-FIFO write scheduler. Holds one 16-bit sample per channel and
// writes each as an atomic little-endian byte frame, granting channels round-robin.
// Optional macro PCM_ARB_TAG_EN: prefix every frame with tag byte {4'hA, channel}.
module pcm_fifo_arbiter #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DROP_CNT_W = 8,
  localparam int unsigned GW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  pcm_fifo_arbiter_if.master    bus,
  output logic                  busy,
  output logic [GW-1:0]         grant_ch,
  output logic [DROP_CNT_W-1:0] drop_count
);

  // Headroom for adding up to 16 drops in one cycle before saturating.
  localparam int unsigned SumW = DROP_CNT_W + 5;

`ifdef PCM_ARB_TAG_EN
  typedef enum logic [1:0] {StIdle, StSendTag, StSendLo, StSendHi} state_e;
`else
  typedef enum logic [1:0] {StIdle, StSendLo, StSendHi} state_e;
`endif

  state_e                  state_q;
  logic [15:0]             hold_q [NUM_CH];
  logic [NUM_CH-1:0]       pend_q;
  logic [15:0]             frame_q;
  logic [GW-1:0]           grant_q;
  logic [DROP_CNT_W-1:0]   drop_q;

  logic                    gnt_vld;
  logic [GW-1:0]           gnt_idx;
  logic [GW-1:0]           cand;
  logic [NUM_CH-1:0]       gnt_oh;
  logic [NUM_CH-1:0]       drop_vec;
  logic [SumW-1:0]         drop_sum;
  logic [DROP_CNT_W-1:0]   drop_nxt;

  // Round-robin search upward from the last grant; no grant while capture is disabled.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = grant_q;
    cand    = grant_q;
    gnt_oh  = '0;
    if (state_q == StIdle && enable) begin
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
        cand = GW'((32'(grant_q) + i) % NUM_CH);
        if (!gnt_vld && pend_q[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
  end

  // A strobe onto an occupied, non-granted holding register is a drop; sum and saturate.
  always_comb begin
    drop_vec = {NUM_CH{enable}} & bus.pcm_valid & pend_q & ~gnt_oh;
    drop_sum = SumW'(drop_q);
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      drop_sum = drop_sum + SumW'(drop_vec[c]);
    end
    if (drop_sum > SumW'({DROP_CNT_W{1'b1}})) drop_nxt = '1;
    else                                       drop_nxt = drop_sum[DROP_CNT_W-1:0];
  end

  // Per-channel holding registers, pending flags and the drop counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q <= '0;
      drop_q <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) hold_q[c] <= '0;
    end else begin
      drop_q <= drop_nxt;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (!enable) begin
          pend_q[c] <= 1'b0;
        end else if (bus.pcm_valid[c] && (!pend_q[c] || gnt_oh[c])) begin
          // On the grant cycle the old sample moves to the frame and the new one takes its place.
          hold_q[c] <= bus.pcm_data[16*c +: 16];
          pend_q[c] <= 1'b1;
        end else if (gnt_oh[c]) begin
          pend_q[c] <= 1'b0;
        end
      end
    end
  end

  // Frame FSM: grant in idle, then emit bytes, stalling while the FIFO is full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      frame_q <= '0;
      grant_q <= GW'(NUM_CH - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_vld) begin
            frame_q <= hold_q[gnt_idx];
            grant_q <= gnt_idx;
`ifdef PCM_ARB_TAG_EN
            state_q <= StSendTag;
`else
            state_q <= StSendLo;
`endif
          end
        end
`ifdef PCM_ARB_TAG_EN
        StSendTag: if (!bus.fifo_full) state_q <= StSendLo;
`endif
        StSendLo:  if (!bus.fifo_full) state_q <= StSendHi;
        StSendHi:  if (!bus.fifo_full) state_q <= StIdle;
        default:   state_q <= StIdle;
      endcase
    end
  end

  // Write strobe and byte decode straight from state; suppressed during reset.
  always_comb begin
    bus.fifo_wr_en = 1'b0;
    bus.fifo_wdata = '0;
    unique case (state_q)
`ifdef PCM_ARB_TAG_EN
      StSendTag: begin
        bus.fifo_wr_en = !bus.fifo_full && rst_n;
        bus.fifo_wdata = {4'hA, 4'(grant_q)};
      end
`endif
      StSendLo: begin
        bus.fifo_wr_en = !bus.fifo_full && rst_n;
        bus.fifo_wdata = frame_q[7:0];
      end
      StSendHi: begin
        bus.fifo_wr_en = !bus.fifo_full && rst_n;
        bus.fifo_wdata = frame_q[15:8];
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign grant_ch   = grant_q;
  assign drop_count = drop_q;

endmodule
